// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port, fixed-latency 64-bit memory between instruction fetch and
// load/store. Data has priority, and a streak limit keeps fetch from being starved.
module imem_dmem_arbiter #(
    parameter int LAT        = 2,
    parameter int MAX_STREAK = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_ready,
    output logic [63:0] d_rdata,
    output logic        d_stall,
    output logic        m_en,
    output logic        m_we,
    output logic [63:0] m_addr,
    output logic [63:0] m_wdata,
    input  logic [63:0] m_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  lat_q;
    logic [2:0]  streak_q;
    logic [2:0]  streak_d;
    logic        store_q;
    logic        m_en_q;
    logic        m_we_q;
    logic [63:0] m_addr_q;
    logic [63:0] m_wdata_q;
    logic        if_ready_q;
    logic        d_ready_q;
    logic [31:0] if_rdata_q;
    logic [63:0] d_rdata_q;

    logic ifEff;
    logic dEff;
    logic grantData;
    logic grantFetch;
    logic respCycle;

    assign ifEff      = if_req & ~if_ready_q;
    assign dEff       = d_req & ~d_ready_q;
    assign grantData  = dEff & ~(ifEff & (streak_q == 3'(MAX_STREAK)));
    assign grantFetch = ifEff & ~grantData;
    // No grant while a ready pulse is out: every requester gets one cycle to
    // update or drop its request before the next arbitration.
    assign respCycle  = if_ready_q | d_ready_q;
    assign streak_d   = (grantData && ifEff) ? streak_q + 3'd1 : 3'd0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            lat_q      <= 4'd0;
            streak_q   <= 3'd0;
            store_q    <= 1'b0;
            m_en_q     <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= 64'd0;
            m_wdata_q  <= 64'd0;
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            if_rdata_q <= 32'd0;
            d_rdata_q  <= 64'd0;
        end else begin
            m_en_q     <= 1'b0;
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!respCycle && (grantData || grantFetch)) begin
                        m_en_q   <= 1'b1;
                        lat_q    <= 4'(LAT);
                        streak_q <= streak_d;
                        if (grantData) begin
                            state_q   <= DATA;
                            m_we_q    <= d_we;
                            m_addr_q  <= d_addr;
                            m_wdata_q <= d_wdata;
                            store_q   <= d_we;
                        end else begin
                            state_q   <= FETCH;
                            m_we_q    <= 1'b0;
                            m_addr_q  <= if_addr;
                            m_wdata_q <= 64'd0;
                            store_q   <= 1'b0;
                        end
                    end
                end
                FETCH, DATA: begin
                    if (lat_q == 4'd0) begin
                        state_q <= IDLE;
                        if (state_q == FETCH) begin
                            if_rdata_q <= m_rdata[31:0];
                            if_ready_q <= 1'b1;
                        end else begin
                            if (!store_q) begin
                                d_rdata_q <= m_rdata;
                            end
                            d_ready_q <= 1'b1;
                        end
                    end else begin
                        lat_q <= lat_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_en     = m_en_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign if_ready = if_ready_q;
    assign d_ready  = d_ready_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign if_stall = if_req & ~if_ready_q;
    assign d_stall  = d_req & ~d_ready_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Bench for imem_dmem_arbiter: a memory device, queue-driven requesters and a
// transaction-level model predicting every grant, ready pulse and read value.
module tb_imem_dmem_arbiter;

    localparam int LAT = 2;
    localparam int MAX = 2;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } dItem_t;

    typedef struct {
        int          cyc;
        logic        isData;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } mEv_t;

    typedef struct {
        int          cyc;
        logic [63:0] data;
    } rEv_t;

    logic        clock;
    logic        reset;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_ready;
    logic [63:0] d_rdata;
    logic        d_stall;
    logic        m_en;
    logic        m_we;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [63:0] m_rdata;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [63:0] fq[$];
    dItem_t      dq[$];
    mEv_t        mEvQ[$];
    rEv_t        ifEvQ[$];
    rEv_t        dEvQ[$];
    mEv_t        expM[$];
    rEv_t        expIf[$];
    rEv_t        expD[$];
    bit          expIfRdy[int];
    bit          expDRdy[int];
    logic [63:0] mem[logic [63:0]];
    logic [63:0] mmem[logic [63:0]];
    logic [63:0] rdAt[int];
    int          mStreak = 0;
    logic [63:0] mLastD  = 64'd0;

    imem_dmem_arbiter #(.LAT(LAT), .MAX_STREAK(MAX)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_rdata(if_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata), .d_stall(d_stall),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    // Clock and cycle counter: cycle k starts at the k-th rising edge
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    function automatic logic [63:0] memInit(input logic [63:0] a);
        return {a[31:0] ^ 32'hC3A5_5A3C, ~a[31:0]};
    endfunction

    function automatic logic [63:0] memRead(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return memInit(a);
    endfunction

    function automatic logic [63:0] mmemRead(input logic [63:0] a);
        if (mmem.exists(a)) return mmem[a];
        return memInit(a);
    endfunction

    // Memory device: records each command, schedules read data exactly LAT
    // cycles after the command cycle and drives X at every other time
    initial begin
        mEv_t ev;
        rEv_t re;
        forever begin
            @(negedge clock);
            if (reset && m_en) begin
                ev = '{cyc: cyc, isData: 1'b0, we: m_we, addr: m_addr, wdata: m_wdata};
                mEvQ.push_back(ev);
                if (m_we) mem[m_addr] = m_wdata;
                else      rdAt[cyc + LAT] = memRead(m_addr);
            end
            if (if_ready) begin
                re = '{cyc: cyc, data: {32'd0, if_rdata}};
                ifEvQ.push_back(re);
            end
            if (d_ready) begin
                re = '{cyc: cyc, data: d_rdata};
                dEvQ.push_back(re);
            end
        end
    end

    initial begin
        m_rdata = 'x;
        forever begin
            @(posedge clock);
            #1;
            if (rdAt.exists(cyc)) m_rdata = rdAt[cyc];
            else                  m_rdata = 'x;
        end
    end

    // Requesters: present the head of each queue, hold it through its ready
    // cycle and move on (or drop the request) in the following cycle
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if_req  = (fq.size() > 0);
            if_addr = (fq.size() > 0) ? fq[0] : 64'd0;
            d_req   = (dq.size() > 0);
            d_we    = (dq.size() > 0) ? dq[0].we : 1'b0;
            d_addr  = (dq.size() > 0) ? dq[0].addr : 64'd0;
            d_wdata = (dq.size() > 0) ? dq[0].wdata : 64'd0;
            @(negedge clock);
            if (if_ready && fq.size() > 0) void'(fq.pop_front());
            if (d_ready && dq.size() > 0) void'(dq.pop_front());
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: walks the queued requests transaction by transaction,
    // applying data priority and the streak limit, one access at a time
    task automatic modelPredict(input int t0);
        int          fi = 0;
        int          di = 0;
        int          t  = t0;
        logic        pickD;
        logic [63:0] word;
        mEv_t        me;
        rEv_t        re;
        expM.delete(); expIf.delete(); expD.delete();
        expIfRdy.delete(); expDRdy.delete();
        while (fi < fq.size() || di < dq.size()) begin
            pickD = (di < dq.size()) && !((fi < fq.size()) && mStreak == MAX);
            if (pickD) begin
                mStreak = (fi < fq.size()) ? mStreak + 1 : 0;
                me = '{cyc: t + 1, isData: 1'b1, we: dq[di].we, addr: dq[di].addr, wdata: dq[di].wdata};
                if (dq[di].we) mmem[dq[di].addr] = dq[di].wdata;
                else           mLastD = mmemRead(dq[di].addr);
                re = '{cyc: t + LAT + 2, data: mLastD};
                expD.push_back(re);
                expDRdy[t + LAT + 2] = 1'b1;
                di++;
            end else begin
                mStreak = 0;
                me = '{cyc: t + 1, isData: 1'b0, we: 1'b0, addr: fq[fi], wdata: 64'd0};
                word = mmemRead(fq[fi]);
                re = '{cyc: t + LAT + 2, data: {32'd0, word[31:0]}};
                expIf.push_back(re);
                expIfRdy[t + LAT + 2] = 1'b1;
                fi++;
            end
            expM.push_back(me);
            t += LAT + 3;
        end
    endtask

    // Queues requests (presented from the next cycle on) and predicts them
    task automatic applyStimulus(input logic [63:0] fAddrs[$], input dItem_t dItems[$]);
        mEvQ.delete(); ifEvQ.delete(); dEvQ.delete();
        foreach (fAddrs[i]) fq.push_back(fAddrs[i]);
        foreach (dItems[i]) dq.push_back(dItems[i]);
        modelPredict(cyc + 1);
    endtask

    task automatic runAndCompare(input string tag);
        int budget = 0;
        int n;
        while ((fq.size() > 0 || dq.size() > 0) && budget < 400) begin
            @(negedge clock);
            checkOutput({tag, "_if_stall"}, 64'(if_stall), 64'(if_req && !expIfRdy.exists(cyc)));
            checkOutput({tag, "_d_stall"}, 64'(d_stall), 64'(d_req && !expDRdy.exists(cyc)));
            budget++;
        end
        repeat (4) @(negedge clock);
        checkOutput({tag, "_drained"}, 64'(fq.size() + dq.size()), 64'd0);
        checkOutput({tag, "_men_count"}, 64'(mEvQ.size()), 64'(expM.size()));
        checkOutput({tag, "_ifrdy_count"}, 64'(ifEvQ.size()), 64'(expIf.size()));
        checkOutput({tag, "_drdy_count"}, 64'(dEvQ.size()), 64'(expD.size()));
        n = (mEvQ.size() < expM.size()) ? mEvQ.size() : expM.size();
        for (int i = 0; i < n; i++) begin
            checkOutput({tag, "_men_cycle"}, 64'(mEvQ[i].cyc), 64'(expM[i].cyc));
            checkOutput({tag, "_m_we"}, 64'(mEvQ[i].we), 64'(expM[i].we));
            checkOutput({tag, "_m_addr"}, mEvQ[i].addr, expM[i].addr);
            if (expM[i].isData) checkOutput({tag, "_m_wdata"}, mEvQ[i].wdata, expM[i].wdata);
        end
        n = (ifEvQ.size() < expIf.size()) ? ifEvQ.size() : expIf.size();
        for (int i = 0; i < n; i++) begin
            checkOutput({tag, "_if_ready_cycle"}, 64'(ifEvQ[i].cyc), 64'(expIf[i].cyc));
            checkOutput({tag, "_if_rdata"}, ifEvQ[i].data, expIf[i].data);
        end
        n = (dEvQ.size() < expD.size()) ? dEvQ.size() : expD.size();
        for (int i = 0; i < n; i++) begin
            checkOutput({tag, "_d_ready_cycle"}, 64'(dEvQ[i].cyc), 64'(expD[i].cyc));
            checkOutput({tag, "_d_rdata"}, dEvQ[i].data, expD[i].data);
        end
    endtask

    task automatic checkZeroOutputs(input string tag);
        checkOutput({tag, "_m_en"}, 64'(m_en), 64'd0);
        checkOutput({tag, "_m_we"}, 64'(m_we), 64'd0);
        checkOutput({tag, "_m_addr"}, m_addr, 64'd0);
        checkOutput({tag, "_m_wdata"}, m_wdata, 64'd0);
        checkOutput({tag, "_if_ready"}, 64'(if_ready), 64'd0);
        checkOutput({tag, "_d_ready"}, 64'(d_ready), 64'd0);
        checkOutput({tag, "_if_rdata"}, 64'(if_rdata), 64'd0);
        checkOutput({tag, "_d_rdata"}, d_rdata, 64'd0);
    endtask

    initial begin
        logic [63:0] fA[$];
        dItem_t      dI[$];
        dItem_t      it;
        int          t0;
        int          k;
        int          wait_cnt;

        reset = 1'b0; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem[64'h10]  = 64'h0000_0000_00A0_0093;
        mmem[64'h10] = 64'h0000_0000_00A0_0093;
        mem[64'h30]  = 64'h55;
        mmem[64'h30] = 64'h55;

        // Reset state
        repeat (2) @(negedge clock);
        checkZeroOutputs("reset");
        checkOutput("reset_if_stall", 64'(if_stall), 64'd0);
        checkOutput("reset_d_stall", 64'(d_stall), 64'd0);
        @(posedge clock); #1 reset = 1'b1;
        repeat (2) @(negedge clock);

        // Single fetch with literal instruction word
        fA = '{64'h10}; dI = '{};
        t0 = cyc + 1;
        applyStimulus(fA, dI);
        runAndCompare("t1");
        checkOutput("t1_if_rdata_literal", 64'(if_rdata), 64'h00A0_0093);
        if (mEvQ.size() > 0) checkOutput("t1_men_latency", 64'(mEvQ[0].cyc - t0), 64'd1);

        // Simultaneous fetch and load: data first, fetch follows
        fA = '{64'h40};
        it = '{we: 1'b0, addr: 64'h100, wdata: 64'h0}; dI = '{it};
        t0 = cyc + 1;
        applyStimulus(fA, dI);
        runAndCompare("t2");
        if (mEvQ.size() > 1) begin
            checkOutput("t2_first_addr", mEvQ[0].addr, 64'h100);
            checkOutput("t2_fetch_men_cycle", 64'(mEvQ[1].cyc - t0), 64'd6);
        end

        // Streak limit: D, D, F, D
        fA = '{64'h80}; dI = '{};
        it = '{we: 1'b0, addr: 64'h200, wdata: 64'h0}; dI.push_back(it);
        it.addr = 64'h208; dI.push_back(it);
        it.addr = 64'h210; dI.push_back(it);
        applyStimulus(fA, dI);
        runAndCompare("t3");
        if (mEvQ.size() > 3) checkOutput("t3_third_grant_fetch", mEvQ[2].addr, 64'h80);
        checkOutput("t3_streak_after_fetch", 64'(dut.streak_q), 64'd0);

        // Store leaves d_rdata untouched
        fA = '{}; dI = '{};
        it = '{we: 1'b0, addr: 64'h30, wdata: 64'h0}; dI.push_back(it);
        it = '{we: 1'b1, addr: 64'h20, wdata: 64'hDEAD_BEEF}; dI.push_back(it);
        applyStimulus(fA, dI);
        runAndCompare("t4");
        checkOutput("t4_d_rdata_kept", d_rdata, 64'h55);

        // Request held through its ready cycle gives a single access
        fA = '{64'h18}; dI = '{};
        applyStimulus(fA, dI);
        runAndCompare("t5");

        // Asynchronous reset in the middle of a load
        fA = '{}; it = '{we: 1'b0, addr: 64'h300, wdata: 64'h0}; dI = '{it};
        applyStimulus(fA, dI);
        wait_cnt = 0;
        do begin
            @(negedge clock);
            wait_cnt++;
        end while (!m_en && wait_cnt < 20);
        checkOutput("t6_men_seen", 64'(m_en), 64'd1);
        mEvQ.delete(); ifEvQ.delete(); dEvQ.delete();
        @(posedge clock); #3 reset = 1'b0;
        #1 checkZeroOutputs("t6_async");
        repeat (3) @(negedge clock);
        mStreak = 0; mLastD = 64'd0;
        @(posedge clock); #1 reset = 1'b1;
        k = cyc;
        modelPredict(k);
        runAndCompare("t6_regrant");

        // Randomized mixes of fetches, loads and stores
        for (int s = 0; s < 25; s++) begin
            fA = '{}; dI = '{};
            for (int i = 0; i < $urandom_range(0, 3); i++)
                fA.push_back(64'h1000 + 64'({$urandom_range(0, 15), 3'b000}));
            for (int i = 0; i < $urandom_range(0, 4); i++) begin
                it.we    = $urandom_range(0, 1) == 1;
                it.addr  = 64'h1000 + 64'({$urandom_range(0, 15), 3'b000});
                it.wdata = {$urandom, $urandom};
                dI.push_back(it);
            end
            if (fA.size() == 0 && dI.size() == 0) fA.push_back(64'h1040);
            applyStimulus(fA, dI);
            runAndCompare("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
